link_stack: RTL

//  Parametrised link-register stack: the next generation of the single 8-bit

---
 rtl/link_stack.sv | 93 +++++++++
 1 files changed

// File: rtl/link_stack.sv
// link_stack: circular-buffer stack of return addresses for nested CALL/RET.
// Define LINK_STACK_ERR_EN to add the sticky lr_err overflow/underflow flag.
module link_stack #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lr_in,
   input  logic             lr_en,
   input  logic             pop_en,
   output logic [WIDTH-1:0] LR,
   output logic [CNT_W-1:0] lr_count,
   output logic             lr_empty,
`ifdef LINK_STACK_ERR_EN
   output logic             lr_full,
   output logic             lr_err
`else
   output logic             lr_full
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lr_q, lr_d;
   logic [PTR_W-1:0] top_inc, top_dec;
   logic             empty, full;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   // Explicit wrap so non-power-of-2 depths stay in range.
   assign top_inc = (top_q == PTR_W'(DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
   assign top_dec = (top_q == '0) ? PTR_W'(DEPTH - 1) : top_q - PTR_W'(1);

   always_comb begin
      mem_d = mem_q;
      top_d = top_q;
      cnt_d = cnt_q;
      lr_d  = lr_q;
      if (lr_en && (!pop_en || empty)) begin
         mem_d[top_inc] = lr_in;
         top_d          = top_inc;
         lr_d           = lr_in;
         if (!full) cnt_d = cnt_q + CNT_W'(1);
      end else if (lr_en && pop_en) begin
         mem_d[top_q] = lr_in;
         lr_d         = lr_in;
      end else if (pop_en && !empty) begin
         top_d = top_dec;
         cnt_d = cnt_q - CNT_W'(1);
         lr_d  = (cnt_q == CNT_W'(1)) ? '0 : mem_q[top_dec];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         top_q <= '0;
         cnt_q <= '0;
         lr_q  <= '0;
      end else begin
         mem_q <= mem_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         lr_q  <= lr_d;
      end
   end

`ifdef LINK_STACK_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q | (full & lr_en & ~pop_en) | (empty & pop_en & ~lr_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign lr_err = err_q;
`endif

   assign LR       = lr_q;
   assign lr_count = cnt_q;
   assign lr_empty = empty;
   assign lr_full  = full;

endmodule
